// File: rtl/vote_sequencer.sv
// Five-voter ballot collector: opens a round on start, latches each voter's first
// ballot until all have voted or the window expires, then presents a majority result.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for start; last round's result outputs retained
// COLLECT | latching first ballot per voter, timer running
// DECIDE  | one cycle to tally ballots into the result registers
// DONE    | result presented until result_ack

module vote_sequencer #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [4:0] vote_valid,
    input  logic [4:0] vote_val,
    input  logic       result_ack,
    output logic       busy,
    output logic [4:0] voted,
    output logic       result_valid,
    output logic       majority,
    output logic [2:0] yes_count,
    output logic       timed_out
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DECIDE  = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    state_t     state_next;
    logic [4:0] ballot;
    logic [7:0] timer;
    logic [4:0] take;
    logic [4:0] voted_upd;
    logic [2:0] yes_sum;
    logic       last_cycle;

    // Only voters that have not yet voted this round are latched; first ballot is final.
    always_comb begin
        take       = vote_valid & ~voted;
        voted_upd  = voted | vote_valid;
        last_cycle = (timer == TIMER_LAST);
        yes_sum    = '0;
        for (int i = 0; i < 5; i++) begin
            yes_sum = yes_sum + {2'b00, ballot[i] & voted[i]};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = COLLECT;
                end
            end
            COLLECT: begin
                if ((voted_upd == 5'b11111) || last_cycle) begin
                    state_next = DECIDE;
                end
            end
            DECIDE: begin
                state_next = DONE;
            end
            DONE: begin
                if (result_ack) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            voted     <= '0;
            ballot    <= '0;
            timer     <= '0;
            yes_count <= '0;
            majority  <= 1'b0;
            timed_out <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        voted  <= '0;
                        ballot <= '0;
                        timer  <= '0;
                    end
                end
                COLLECT: begin
                    voted  <= voted_upd;
                    ballot <= (ballot & ~take) | (vote_val & take);
                    timer  <= timer + 8'd1;
                end
                DECIDE: begin
                    yes_count <= yes_sum;
                    majority  <= (yes_sum >= 3'd3);
                    timed_out <= (voted != 5'b11111);
                end
                default: begin
                end
            endcase
        end
    end

    assign busy         = (state != IDLE);
    assign result_valid = (state == DONE);

endmodule

// File: tb/tb_vote_sequencer.sv
// Self-checking bench for vote_sequencer: a ballot model pushes expected results
// into a queue as votes are driven; each scenario pops and compares at DONE.

module tb_vote_sequencer;

    localparam int unsigned TIMEOUT = 16;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [4:0] vote_valid = '0;
    logic [4:0] vote_val = '0;
    logic       result_ack = 1'b0;
    logic       busy;
    logic [4:0] voted;
    logic       result_valid;
    logic       majority;
    logic [2:0] yes_count;
    logic       timed_out;

    int n_tests = 0;
    int n_fail  = 0;

    logic [9:0] sb[$];
    logic [4:0] m_voted;
    logic [4:0] m_ballot;

    vote_sequencer #(.TIMEOUT(TIMEOUT)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .vote_valid  (vote_valid),
        .vote_val    (vote_val),
        .result_ack  (result_ack),
        .busy        (busy),
        .voted       (voted),
        .result_valid(result_valid),
        .majority    (majority),
        .yes_count   (yes_count),
        .timed_out   (timed_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1);
    end

    // Reference model: a voter's first ballot in the round is the one that counts.
    task automatic model_vote(input logic [4:0] v, input logic [4:0] b);
        logic [4:0] fresh;
        fresh    = v & ~m_voted;
        m_ballot = (m_ballot & ~fresh) | (b & fresh);
        m_voted  = m_voted | v;
    endtask

    function automatic logic [9:0] exp_pack();
        logic [2:0] y;
        y = 3'($countones(m_ballot & m_voted));
        return {m_voted, y, (y >= 3'd3), (m_voted != 5'b11111)};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_round();
        m_voted  = '0;
        m_ballot = '0;
        start    = 1'b1;
        step();
        start    = 1'b0;
    endtask

    task automatic drive_vote(input logic [4:0] v, input logic [4:0] b);
        vote_valid = v;
        vote_val   = b;
        model_vote(v, b);
        step();
        vote_valid = '0;
        vote_val   = '0;
    endtask

    task automatic wait_result(output int cyc);
        cyc = 0;
        while (!result_valid && cyc < 64) begin
            step();
            cyc++;
        end
    endtask

    task automatic ack_result();
        result_ack = 1'b1;
        step();
        result_ack = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
        n_tests++;
        if (voted !== 5'b0) begin n_fail++; $display("FAIL reset_voted: got %b required 00000", voted); end
        n_tests++;
        if (result_valid !== 1'b0) begin n_fail++; $display("FAIL reset_result_valid: got %b required 0", result_valid); end
        n_tests++;
        if ({majority, yes_count, timed_out} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_result: got maj=%b yes=%0d to=%b required all 0", majority, yes_count, timed_out);
        end
    endtask

    task automatic test_min_latency();
        logic [9:0] exp;
        logic [9:0] got;
        begin_round();
        drive_vote(5'b11111, 5'b10110);
        sb.push_back(exp_pack());
        n_tests++;
        if ({busy, result_valid} !== 2'b10) begin
            n_fail++;
            $display("FAIL min_latency_decide: got busy=%b rv=%b required busy=1 rv=0", busy, result_valid);
        end
        step();
        n_tests++;
        if (result_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL min_latency_done: got rv=%b required 1", result_valid);
        end
        exp = sb.pop_front();
        got = {voted, yes_count, majority, timed_out};
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL min_latency_result: got %b required %b", got, exp);
        end
        ack_result();
    endtask

    task automatic test_timeout();
        logic [9:0] exp;
        logic [9:0] got;
        int c;
        begin_round();
        drive_vote(5'b00011, 5'b00011);
        sb.push_back(exp_pack());
        wait_result(c);
        n_tests++;
        if (c + 1 != int'(TIMEOUT) + 1) begin
            n_fail++;
            $display("FAIL timeout_latency: got %0d edges required %0d", c + 1, TIMEOUT + 1);
        end
        exp = sb.pop_front();
        got = {voted, yes_count, majority, timed_out};
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL timeout_result: got %b required %b", got, exp);
        end
        ack_result();
    endtask

    task automatic test_final_ballot();
        logic [9:0] exp;
        logic [9:0] got;
        int c;
        begin_round();
        drive_vote(5'b00100, 5'b00100);
        // start and result_ack mid-collect must not disturb the round
        start      = 1'b1;
        result_ack = 1'b1;
        drive_vote(5'b00111, 5'b00011);
        start      = 1'b0;
        result_ack = 1'b0;
        drive_vote(5'b11000, 5'b00000);
        sb.push_back(exp_pack());
        wait_result(c);
        n_tests++;
        if (c != 1) begin
            n_fail++;
            $display("FAIL final_ballot_latency: got %0d required 1", c);
        end
        exp = sb.pop_front();
        got = {voted, yes_count, majority, timed_out};
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL final_ballot_result: got %b required %b", got, exp);
        end
        ack_result();
    endtask

    task automatic test_last_cycle_ballot();
        logic [9:0] exp;
        logic [9:0] got;
        int c;
        begin_round();
        drive_vote(5'b00011, 5'b00011);
        for (int k = 2; k < int'(TIMEOUT); k++) begin
            step();
        end
        drive_vote(5'b10000, 5'b10000);
        sb.push_back(exp_pack());
        wait_result(c);
        n_tests++;
        if (c != 1) begin
            n_fail++;
            $display("FAIL last_cycle_latency: got %0d required 1", c);
        end
        exp = sb.pop_front();
        got = {voted, yes_count, majority, timed_out};
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL last_cycle_result: got %b required %b", got, exp);
        end
        ack_result();
    endtask

    task automatic test_reset_mid();
        logic [9:0] exp;
        logic [9:0] got;
        int c;
        begin_round();
        drive_vote(5'b00111, 5'b00111);
        step();
        #2;
        reset = 1'b1;
        #1;
        n_tests++;
        if ({busy, voted, result_valid, majority, yes_count, timed_out} !== 12'b0) begin
            n_fail++;
            $display("FAIL reset_mid_clear: got busy=%b voted=%b rv=%b maj=%b yes=%0d to=%b required all 0",
                     busy, voted, result_valid, majority, yes_count, timed_out);
        end
        @(negedge clk);
        reset = 1'b0;
        begin_round();
        n_tests++;
        if ({busy, voted} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_first_start: got busy=%b voted=%b required busy=1 voted=00000", busy, voted);
        end
        drive_vote(5'b11111, 5'b00001);
        sb.push_back(exp_pack());
        wait_result(c);
        exp = sb.pop_front();
        got = {voted, yes_count, majority, timed_out};
        n_tests++;
        if (c != 1 || got !== exp) begin
            n_fail++;
            $display("FAIL reset_clean_round: got %b after %0d required %b after 1", got, c, exp);
        end
        ack_result();
    endtask

    task automatic test_done_hold();
        logic [9:0] exp;
        logic [9:0] got;
        int c;
        begin_round();
        drive_vote(5'b11111, 5'b11111);
        sb.push_back(exp_pack());
        wait_result(c);
        exp = sb.pop_front();
        for (int k = 0; k < 5; k++) begin
            start = (k % 2 == 0);
            step();
            got = {voted, yes_count, majority, timed_out};
            n_tests++;
            if (result_valid !== 1'b1 || got !== exp) begin
                n_fail++;
                $display("FAIL done_hold_%0d: got rv=%b res=%b required rv=1 res=%b", k, result_valid, got, exp);
            end
        end
        start      = 1'b1;
        result_ack = 1'b1;
        step();
        start      = 1'b0;
        result_ack = 1'b0;
        n_tests++;
        if ({busy, result_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL done_ack_idle: got busy=%b rv=%b required 0 0", busy, result_valid);
        end
        step();
        got = {voted, yes_count, majority, timed_out};
        n_tests++;
        if (busy !== 1'b0 || got !== exp) begin
            n_fail++;
            $display("FAIL idle_retain: got busy=%b res=%b required busy=0 res=%b", busy, got, exp);
        end
    endtask

    initial begin
        repeat (3) @(posedge clk);
        test_reset();
        @(negedge clk);
        reset = 1'b0;
        test_min_latency();
        test_timeout();
        test_final_ballot();
        test_last_cycle_ballot();
        test_reset_mid();
        test_done_hold();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vote_sequencer.md
VOTE_SEQUENCER -- requirements
Module: vote_sequencer

Interface
REQ-001 Parameter: TIMEOUT, default 16, collection window length in clock cycles; legal range 1..255.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  one-cycle request to open a voting round.
REQ-005 vote_valid  input  5  per-voter strobe; bit i high means voter i presents a ballot this cycle.
REQ-006 vote_val  input  5  per-voter ballot value; bit i is valid only when vote_valid[i]=1.
REQ-007 result_ack  input  1  consumer acknowledge of the presented result.
REQ-008 busy  output  1  high in every state except IDLE.
REQ-009 voted  output  5  registered mask of voters whose ballot was latched this round.
REQ-010 result_valid  output  1  high while a result is presented (state DONE).
REQ-011 majority  output  1  registered result; 1 when yes_count >= 3.
REQ-012 yes_count  output  3  registered count of latched 1-ballots, range 0..5.
REQ-013 timed_out  output  1  registered; 1 when the round closed by timeout with voted != 5'b11111.

Function
REQ-014 States: IDLE, COLLECT, DECIDE, DONE; state register, ballot register and voted mask are updated only on clk rising edge or reset.
REQ-015 IDLE: start=1 -> COLLECT; voted, ballot register and timer clear to 0 on that edge; otherwise stay.
REQ-016 start is ignored in every state other than IDLE.
REQ-017 COLLECT: for each i, vote_valid[i]=1 and voted[i]=0 -> ballot[i] <= vote_val[i], voted[i] <= 1.
REQ-018 A voter's first latched ballot is final; later strobes from the same voter in the round are ignored.
REQ-019 Strobes in IDLE, DECIDE and DONE are ignored.
REQ-020 Timer: 8-bit, increments by 1 every COLLECT cycle; no wrap within legal TIMEOUT.
REQ-021 COLLECT -> DECIDE when the updated voted mask equals 5'b11111, or when timer == TIMEOUT-1, whichever occurs first.
REQ-022 A ballot strobed in the final (timeout) COLLECT cycle is counted.
REQ-023 Missing ballots count as 0.
REQ-024 DECIDE: one cycle; yes_count <= popcount(ballot & voted), majority <= (popcount >= 3), timed_out <= (voted != 5'b11111); -> DONE.
REQ-025 DONE: result_valid=1; majority, yes_count, timed_out, voted held stable until the edge at which result_ack=1 is sampled, then -> IDLE.
REQ-026 result_ack outside DONE is ignored; result_ack and start together in DONE -> IDLE only (start not taken).
REQ-027 Minimum latency: start sampled at edge N, all five strobes at edge N+1 -> result_valid high after edge N+2.
REQ-028 Maximum latency: start at edge N, no full vote -> DECIDE after edge N+TIMEOUT, result_valid high after edge N+TIMEOUT+1.
REQ-029 Result outputs retain the last round's values in IDLE until the next DECIDE overwrites them.

Reset
REQ-030 reset=1 forces IDLE immediately regardless of clk, including mid-COLLECT or in DONE; the partial round is discarded.
REQ-031 Reset values: busy=0, voted=0, result_valid=0, majority=0, yes_count=0, timed_out=0, timer=0, ballot register=0.
REQ-032 First start is accepted on the first rising edge after reset deasserts.

Verification
REQ-033 start; next cycle vote_valid=11111, vote_val=10110 -> result_valid 2 cycles later, yes_count=3, majority=1, timed_out=0.
REQ-034 TIMEOUT=16; start; only voters 0,1 vote 1 -> DONE after 17 cycles, voted=00011, yes_count=2, majority=0, timed_out=1.
REQ-035 Voter 2 strobes 1 then 0 in later cycle, others vote 1,1,0,0 -> ballot 1 retained, yes_count=3, majority=1.
REQ-036 Voter 4 strobes 1 exactly in timer==TIMEOUT-1 cycle with voters 0,1 already 1 -> yes_count=3, majority=1, timed_out=1.
REQ-037 reset pulsed mid-COLLECT with voted=00111 -> all outputs 0 immediately; later start begins a clean round.
REQ-038 In DONE hold result_ack=0 for 5 cycles with start pulses -> outputs stable, no new round; result_ack=1 -> IDLE next edge, busy=0.
